// File: rtl/coeff_table_loader.sv
// coeff_table_loader: runtime-writable a/b/c coefficient table for the
// quadratic approximation unit. Records stream in over a valid/ready port
// and fill the table in address order. Lookups are registered, one result
// per request.
// Optional feature: define COEFF_LOADER_CHECKSUM_EN to require an XOR
// checksum beat after the last record before the table is declared valid.
module coeff_table_loader #(
  parameter int ADDR_W = 6,
  parameter int A_W    = 18,
  parameter int B_W    = 18,
  parameter int C_W    = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_start,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [A_W+B_W+C_W-1:0]   wr_data,
  output logic                     load_busy,
  output logic                     table_valid,
  output logic                     load_err,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic                     rd_valid,
  output logic [A_W-1:0]           a,
  output logic [B_W-1:0]           b,
  output logic [C_W-1:0]           c
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int REC_W = A_W + B_W + C_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

`ifdef COEFF_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOAD} state_t;
`endif

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  wr_addr;
  logic [REC_W-1:0]   mem [DEPTH];

  // A record beat is written only in LOAD; a simultaneous restart discards it.
  logic               rec_beat_p0;
  logic               rec_last_p0;
  logic               rd_hit_p0;

  assign rec_beat_p0 = (state == S_LOAD) && wr_valid && !load_start;
  assign rec_last_p0 = rec_beat_p0 && (wr_addr == LAST_ADDR);
  assign rd_hit_p0   = rd_en && table_valid;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and decoded handshake outputs.
  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b0;
    load_busy = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (load_start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        wr_ready = 1'b1;
        if (load_start) begin
          state_nxt = S_LOAD;
        end else if (rec_last_p0) begin
`ifdef COEFF_LOADER_CHECKSUM_EN
          state_nxt = S_CHECK;
`else
          state_nxt = S_IDLE;
`endif
        end
      end
`ifdef COEFF_LOADER_CHECKSUM_EN
      S_CHECK: begin
        wr_ready = 1'b1;
        if (load_start)    state_nxt = S_LOAD;
        else if (wr_valid) state_nxt = S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef COEFF_LOADER_CHECKSUM_EN
  logic [REC_W-1:0] acc;
  logic             err_q;

  // Load control: write pointer, running XOR, verdict flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr     <= '0;
      acc         <= '0;
      table_valid <= 1'b0;
      err_q       <= 1'b0;
    end else if (load_start) begin
      wr_addr     <= '0;
      acc         <= '0;
      table_valid <= 1'b0;
      err_q       <= 1'b0;
    end else if (rec_beat_p0) begin
      wr_addr     <= wr_addr + ADDR_W'(1);
      acc         <= acc ^ wr_data;
    end else if ((state == S_CHECK) && wr_valid) begin
      table_valid <= (wr_data == acc);
      err_q       <= (wr_data != acc);
    end
  end

  assign load_err = err_q;
`else
  // Load control: write pointer and completion flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr     <= '0;
      table_valid <= 1'b0;
    end else if (load_start) begin
      wr_addr     <= '0;
      table_valid <= 1'b0;
    end else if (rec_beat_p0) begin
      wr_addr     <= wr_addr + ADDR_W'(1);
      if (rec_last_p0) table_valid <= 1'b1;
    end
  end

  assign load_err = 1'b0;
`endif

  // Table storage; not reset, contents are only trusted once table_valid is set.
  always_ff @(posedge clk) begin
    if (rec_beat_p0) mem[wr_addr] <= wr_data;
  end

  // ---- lookup stage: registered read, outputs hold on a refused request ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      a        <= '0;
      b        <= '0;
      c        <= '0;
    end else begin
      rd_valid <= rd_hit_p0;
      if (rd_hit_p0) {a, b, c} <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_coeff_table_loader.sv
// Self-checking bench for coeff_table_loader: table-driven lookups on a known
// pattern, random loads checked against a reference copy of the table, and
// hand-written sequences for reset, restart and refused reads.
module tb_coeff_table_loader;

  localparam int ADDR_W = 6;
  localparam int A_W = 18, B_W = 18, C_W = 18;
  localparam int DEPTH = 2**ADDR_W;
  localparam int REC_W = A_W + B_W + C_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_start = 1'b0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [REC_W-1:0]  wr_data = '0;
  logic              load_busy, table_valid, load_err;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_valid;
  logic [A_W-1:0]    a;
  logic [B_W-1:0]    b;
  logic [C_W-1:0]    c;

  coeff_table_loader #(.ADDR_W(ADDR_W), .A_W(A_W), .B_W(B_W), .C_W(C_W)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_data(wr_data), .load_busy(load_busy),
    .table_valid(table_valid), .load_err(load_err), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_valid(rd_valid), .a(a), .b(b), .c(c)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [REC_W-1:0] stim    [DEPTH];
  logic [REC_W-1:0] ref_mem [DEPTH];
  logic [A_W-1:0]   last_a = '0;
  logic [B_W-1:0]   last_b = '0;
  logic [C_W-1:0]   last_c = '0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [A_W-1:0]    ea;
    logic [B_W-1:0]    eb;
    logic [C_W-1:0]    ec;
  } vec_t;
  vec_t vt [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [REC_W-1:0] rnd_rec();
    return REC_W'({$urandom, $urandom});
  endfunction

  // Sends the DEPTH records in stim (plus checksum beat when enabled).
  // skip_start: the caller already issued the start pulse.
  task automatic do_load(input bit toggle, input bit skip_start, input bit bad_sum);
    logic [REC_W-1:0] sum;
    bit               expect_ok;
    sum = '0;
    if (!skip_start) begin
      load_start = 1'b1; wr_valid = 1'b0;
      tick();
      load_start = 1'b0;
    end
    check("busy_in_load", {63'd0, load_busy}, 64'd1);
    check("tv_low_in_load", {63'd0, table_valid}, 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      if (toggle && i > 0) begin
        wr_valid = 1'b0;
        tick();
      end
      wr_valid = 1'b1;
      wr_data  = stim[i];
      if (i == 0 || i == DEPTH - 1) check("wr_ready_in_load", {63'd0, wr_ready}, 64'd1);
      tick();
      sum ^= stim[i];
    end
    wr_valid = 1'b0;
    expect_ok = 1'b1;
`ifdef COEFF_LOADER_CHECKSUM_EN
    check("tv_low_in_check", {63'd0, table_valid}, 64'd0);
    check("busy_in_check", {63'd0, load_busy}, 64'd1);
    wr_valid = 1'b1;
    wr_data  = bad_sum ? (sum ^ REC_W'(1)) : sum;
    tick();
    wr_valid = 1'b0;
    expect_ok = !bad_sum;
    check("load_err_after", {63'd0, load_err}, {63'd0, !expect_ok});
`else
    check("load_err_tied0", {63'd0, load_err}, 64'd0);
`endif
    check("tv_after_load", {63'd0, table_valid}, {63'd0, expect_ok});
    check("busy_after_load", {63'd0, load_busy}, 64'd0);
    if (expect_ok)
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = stim[i];
  endtask

  // One read request; hold keeps rd_en asserted for back-to-back use.
  task automatic do_read(input logic [ADDR_W-1:0] addr, input bit exp_vld, input bit hold);
    logic [REC_W-1:0] r;
    rd_en = 1'b1; rd_addr = addr;
    tick();
    if (!hold) rd_en = 1'b0;
    check("rd_valid", {63'd0, rd_valid}, {63'd0, exp_vld});
    if (exp_vld) begin
      r = ref_mem[addr];
      last_a = r[REC_W-1 -: A_W];
      last_b = r[B_W+C_W-1 -: B_W];
      last_c = r[C_W-1:0];
    end
    check("rd_a", 64'(a), 64'(last_a));
    check("rd_b", 64'(b), 64'(last_b));
    check("rd_c", 64'(c), 64'(last_c));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 6; i++) begin
      logic [ADDR_W-1:0] ad;
      ad = (i == 0) ? 6'd5 : (i == 1) ? 6'd0 : (i == 2) ? 6'd63 :
           (i == 3) ? 6'd1 : (i == 4) ? 6'd32 : 6'd17;
      vt[i].addr = ad;
      vt[i].ea = A_W'(ad);
      vt[i].eb = B_W'(2 * ad);
      vt[i].ec = C_W'(3 * ad);
    end

    // Reset state
    #3;
    check("rst_wr_ready", {63'd0, wr_ready}, 64'd0);
    check("rst_busy", {63'd0, load_busy}, 64'd0);
    check("rst_tv", {63'd0, table_valid}, 64'd0);
    check("rst_err", {63'd0, load_err}, 64'd0);
    check("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    check("rst_abc", 64'({a, b, c} != '0), 64'd0);
    #4 rst = 1'b0;
    tick();

    // Reset in the middle of a load stream
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wr_valid = 1'b1; wr_data = rnd_rec(); tick();
    end
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", {63'd0, load_busy}, 64'd0);
    check("midrst_ready", {63'd0, wr_ready}, 64'd0);
    check("midrst_tv", {63'd0, table_valid}, 64'd0);
    check("midrst_rd_valid", {63'd0, rd_valid}, 64'd0);
    wr_valid = 1'b0;
    #3 rst = 1'b0;
    tick();
    do_read(6'd3, 1'b0, 1'b0);

    // Known pattern {i,2i,3i}, then table-driven lookups
    for (int i = 0; i < DEPTH; i++)
      stim[i] = {A_W'(i), B_W'(2 * i), C_W'(3 * i)};
    do_load(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      rd_en = 1'b1; rd_addr = vt[i].addr;
      tick();
      rd_en = 1'b0;
      check("vec_rd_valid", {63'd0, rd_valid}, 64'd1);
      check("vec_a", 64'(a), 64'(vt[i].ea));
      check("vec_b", 64'(b), 64'(vt[i].eb));
      check("vec_c", 64'(c), 64'(vt[i].ec));
      last_a = vt[i].ea; last_b = vt[i].eb; last_c = vt[i].ec;
      tick();
      check("vec_pulse_low", {63'd0, rd_valid}, 64'd0);
    end

    // Throttled load of random data, random back-to-back reads
    for (int i = 0; i < DEPTH; i++) stim[i] = rnd_rec();
    do_load(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++)
      do_read(ADDR_W'($urandom_range(0, DEPTH - 1)), 1'b1, 1'b1);
    rd_en = 1'b0;
    tick();
    check("b2b_end_low", {63'd0, rd_valid}, 64'd0);

    // Restart at beat 10; the restarting cycle also carries a discarded beat
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1'b1; wr_data = rnd_rec(); tick();
    end
    load_start = 1'b1; wr_valid = 1'b1; wr_data = rnd_rec();
    tick();
    load_start = 1'b0; wr_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) stim[i] = rnd_rec();
    do_load(1'b0, 1'b1, 1'b0);
    do_read(6'd0, 1'b1, 1'b0);
    do_read(6'd10, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++)
      do_read(ADDR_W'($urandom_range(0, DEPTH - 1)), 1'b1, 1'b0);

    // Read refused while the table is invalid; outputs hold
    load_start = 1'b1; tick(); load_start = 1'b0;
    do_read(6'd7, 1'b0, 1'b0);
    do_read(6'd8, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) stim[i] = rnd_rec();
    do_load(1'b0, 1'b1, 1'b0);
    do_read(6'd8, 1'b1, 1'b0);

`ifdef COEFF_LOADER_CHECKSUM_EN
    // Bad checksum: table refused, reads refused; then a good reload
    for (int i = 0; i < DEPTH; i++) stim[i] = rnd_rec();
    do_load(1'b0, 1'b0, 1'b1);
    do_read(6'd9, 1'b0, 1'b0);
    do_load(1'b0, 1'b0, 1'b0);
    do_read(6'd9, 1'b1, 1'b0);
    check("err_cleared", {63'd0, load_err}, 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
